// File: rtl/b_uart.sv
// b_uart: runtime-programmable 8N1 UART with fractional-phase bit timers.
// Optional: define B_UART_FRAMING_CHECK_EN to discard frames whose stop bit samples 0.
`default_nettype none

module b_uart #(
    parameter int CLKFREQ = 1000000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [31:0] baud,
    input  logic        rx,
    output logic        tx,
    input  logic        rd,
    input  logic        wr,
    output logic        valid,
    output logic        busy,
    input  logic [7:0]  tx_data,
    output logic [7:0]  rx_data
);

    localparam logic [32:0] FREQ = 33'(CLKFREQ);
    localparam logic [32:0] HALF = 33'(CLKFREQ / 2);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    tx_state_e   tx_state_q, tx_state_d;
    logic [32:0] tx_acc_q, tx_acc_d;
    logic [8:0]  tx_sh_q, tx_sh_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic        tx_q, tx_d;

    rx_state_e   rx_state_q, rx_state_d;
    logic [32:0] rx_acc_q, rx_acc_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        valid_q, valid_d;
    logic        rx_s1_q, rx_s2_q;

    // acc stays below FREQ, so baud = 0 never ticks and the engines stall.
    logic [32:0] tx_sum, rx_sum, tx_step, rx_step;
    logic        tx_tick, rx_tick, stop_ok, rx_done;

    assign tx_sum  = tx_acc_q + {1'b0, baud};
    assign tx_tick = (tx_sum >= FREQ);
    assign tx_step = tx_tick ? (tx_sum - FREQ) : tx_sum;
    assign rx_sum  = rx_acc_q + {1'b0, baud};
    assign rx_tick = (rx_sum >= FREQ);
    assign rx_step = rx_tick ? (rx_sum - FREQ) : rx_sum;

`ifdef B_UART_FRAMING_CHECK_EN
    assign stop_ok = rx_s2_q;
`else
    assign stop_ok = 1'b1;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_acc_d   = tx_acc_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (wr) begin
                    tx_state_d = TX_SEND;
                    tx_acc_d   = '0;
                    tx_sh_d    = {1'b1, tx_data};
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                end
            end
            TX_SEND: begin
                tx_acc_d = tx_step;
                if (tx_tick) begin
                    if (tx_cnt_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                    end else begin
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_acc_d   = rx_acc_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_acc_d   = HALF;
                end
            end
            RX_START: begin
                rx_acc_d = rx_step;
                if (rx_tick) begin
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = '0;
                end
            end
            RX_DATA: begin
                rx_acc_d = rx_step;
                if (rx_tick) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    if (rx_cnt_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_acc_d = rx_step;
                if (rx_tick) begin
                    rx_state_d = RX_IDLE;
                    if (stop_ok) begin
                        rx_data_d = rx_sh_q;
                        rx_done   = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        // Completion beats a simultaneous rd.
        valid_d = rx_done ? 1'b1 : (rd ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= TX_IDLE;
            tx_acc_q   <= '0;
            tx_sh_q    <= '1;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_acc_q   <= '0;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            valid_q    <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_acc_q   <= tx_acc_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_acc_q   <= rx_acc_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            valid_q    <= valid_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
        end
    end

    assign tx      = tx_q;
    assign busy    = (tx_state_q == TX_SEND);
    assign valid   = valid_q;
    assign rx_data = rx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_b_uart.sv
// tb_b_uart: directed, table-driven bench for b_uart at CLKFREQ = 16, baud = 1.
`default_nettype none

module tb_b_uart;

    logic        clk = 1'b0;
    logic        resetq;
    logic [31:0] baud;
    logic        rx;
    logic        tx;
    logic        rd;
    logic        wr;
    logic        valid;
    logic        busy;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data;

    int checks = 0;
    int errors = 0;

    b_uart #(.CLKFREQ(16)) dut (
        .clk     (clk),
        .resetq  (resetq),
        .baud    (baud),
        .rx      (rx),
        .tx      (tx),
        .rd      (rd),
        .wr      (wr),
        .valid   (valid),
        .busy    (busy),
        .tx_data (tx_data),
        .rx_data (rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] inject;
        logic [9:0] exp_seq;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd_after;
        logic       exp_valid;
        logic [7:0] exp_data;
    } rx_vec_t;

    tx_vec_t tx_vec [2];
    rx_vec_t rx_vec [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one byte; a second wr lands mid-frame and must be ignored.
    task automatic run_tx(input tx_vec_t v);
        @(negedge clk);
        tx_data = v.data;
        wr      = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 160; j++) begin
            @(negedge clk);
            if (j == 0) begin
                wr = 1'b0;
                chk("busy_start", 32'(busy), 32'd1);
            end
            if (j == 49) begin
                wr      = 1'b1;
                tx_data = v.inject;
            end
            if (j == 50) wr = 1'b0;
            if ((j % 16) == 8 && j < 160)
                chk($sformatf("tx_bit%0d_%02h", j / 16, v.data), 32'(tx), 32'(v.exp_seq[j / 16]));
            if (j == 159) chk("busy_last", 32'(busy), 32'd1);
            if (j == 160) begin
                chk("busy_end", 32'(busy), 32'd0);
                chk("tx_idle", 32'(tx), 32'd1);
            end
            if (j < 160) @(posedge clk);
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rx = f[k];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        tx_vec[0] = '{8'hA5, 8'h3C, 10'b1101001010};
        tx_vec[1] = '{8'h3C, 8'hFF, 10'b1001111000};

        rx_vec[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A};
        rx_vec[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11};
        rx_vec[2] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22};
`ifdef B_UART_FRAMING_CHECK_EN
        rx_vec[3] = '{8'h77, 1'b0, 1'b0, 1'b0, 8'h22};
`else
        rx_vec[3] = '{8'h77, 1'b0, 1'b0, 1'b1, 8'h77};
`endif

        resetq  = 1'b0;
        baud    = 32'd1;
        rx      = 1'b1;
        rd      = 1'b0;
        wr      = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        resetq = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 2; i++) run_tx(tx_vec[i]);

        // Short low glitch must be rejected as a false start.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_valid", 32'(valid), 32'd0);
        chk("glitch_data", 32'(rx_data), 32'h00);

        // rd with nothing pending leaves valid low.
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("rd_idle_valid", 32'(valid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            drive_frame(rx_vec[i].data, rx_vec[i].stop);
            chk($sformatf("rx_valid_%02h", rx_vec[i].data), 32'(valid), 32'(rx_vec[i].exp_valid));
            chk($sformatf("rx_data_%02h", rx_vec[i].data), 32'(rx_data), 32'(rx_vec[i].exp_data));
            if (rx_vec[i].rd_after) begin
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                chk($sformatf("rd_clear_%02h", rx_vec[i].data), 32'(valid), 32'd0);
                chk($sformatf("rd_hold_%02h", rx_vec[i].data), 32'(rx_data), 32'(rx_vec[i].exp_data));
            end
        end

        // Asynchronous reset in the middle of a transmission.
        tx_data = 8'hA5;
        wr      = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_tx_bit", 32'(tx), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 resetq = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_data", 32'(rx_data), 32'h00);
        @(negedge clk);
        resetq = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_tx", 32'(tx), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/b_uart.md
# b_uart

Runtime-programmable 8N1 UART for the j1 SoC, clocked from the system fast clock. The CPU writes the bit rate to `baud`, strobes `wr` to send a byte and `rd` to acknowledge a received one; `valid`/`busy` are read back as status bits. Bit timing uses a fractional phase accumulator, so any integer baud rate works without a divider table.

## Interface
- `CLKFREQ`, default 1000000: `clk` frequency in Hz; the accumulator modulus.
- `clk`  in  1  system clock; all logic on rising edge.
- `resetq`  in  1  asynchronous active-low reset.
- `baud`  in  32  bit rate in bits/s; sampled every cycle.
- `rx`  in  1  serial input, asynchronous, idle high.
- `tx`  out  1  serial output, idle high.
- `rd`  in  1  one-cycle strobe: consume received byte.
- `wr`  in  1  one-cycle strobe: transmit `tx_data`.
- `valid`  out  1  received byte waiting in `rx_data`.
- `busy`  out  1  transmitter sending a frame.
- `tx_data`  in  8  byte to send; sampled only on accepted `wr`.
- `rx_data`  out  8  last received byte; held until next byte completes.

## Operation
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Bit timer (TX and RX each own one): 33-bit accumulator; each cycle `acc += baud`; when result ≥ `CLKFREQ`, subtract `CLKFREQ` and emit a bit tick. Average bit length = `CLKFREQ/baud` cycles.
- Legal `baud`: 1 .. `CLKFREQ/4`. `baud` = 0 stalls both engines in place (no tick); a change mid-frame takes effect on the next cycle.
- TX states IDLE → SEND (10 bits). `wr` in IDLE: latch `tx_data`, clear accumulator, enter SEND. `wr` while `busy` is ignored, no queueing. After the stop bit's tick, return to IDLE.
- RX: `rx` passes a 2-flop synchronizer. States IDLE → START → DATA → STOP.
  - IDLE: synchronized `rx` = 0 → accumulator preset to `CLKFREQ/2`, enter START.
  - START tick: line still 0 → DATA; else false start → IDLE.
  - DATA: 8 ticks, shift in LSB first.
  - STOP tick: line 1 → load `rx_data`, set `valid`; return to IDLE either way.
- `valid` cleared by `rd`. New byte completing while `valid` = 1 overwrites `rx_data`; `valid` stays 1. `rd` and completion in the same cycle: completion wins, `valid` = 1. `rd` with `valid` = 0 has no effect.
- TX and RX are fully independent; full duplex.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `valid` = 0, `rx_data` = 0, both engines IDLE, accumulators 0.
- `wr` at edge N: `busy` = 1 and `tx` = 0 from cycle N+1; `tx` changes only on ticks; `busy` falls in the cycle after the stop-bit tick.
- RX: `valid` rises 1 cycle after the stop-bit sample. Input-to-detect latency is 2 cycles (synchronizer).
- Reset assertion mid-frame aborts both engines immediately; `tx` returns to 1 asynchronously.

## Configuration
- `B_UART_FRAMING_CHECK_EN` defined: stop bit sampled 0 → byte discarded, `valid` and `rx_data` unchanged.
- Undefined: stop bit not checked; every frame reaching STOP is delivered.

## Test plan
- Reset: hold `resetq` = 0 → `tx` = 1, `busy` = 0, `valid` = 0, `rx_data` = 0x00.
- `CLKFREQ` = 16, `baud` = 1, `wr` with `tx_data` = 0xA5 at cycle 0 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each 16 cycles; `busy` high cycles 1–160, low at 161.
- Second `wr` (0x3C) at cycle 50 of that frame → ignored; only 0xA5 transmitted.
- Drive `rx` with a 0x5A frame at 16 cycles/bit → `valid` = 1, `rx_data` = 0x5A; `rd` pulse → `valid` = 0 next cycle.
- 0x11 then 0x22 received without `rd` → `rx_data` = 0x22, `valid` = 1; 4-cycle low glitch on `rx` → no reception.
- Frame 0x77 with stop bit 0 → with `B_UART_FRAMING_CHECK_EN`: `valid` stays 0; without: `valid` = 1, `rx_data` = 0x77.
